// File: rtl/mips_rf_pkg.sv
// Shared types and constants for the register file and its pending-write scoreboard.
package mips_rf_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_CNT_W  = 2;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

  // Largest count a CNT_W-bit pending counter can hold.
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int CNT_MAX = cnt_max(DEF_CNT_W);

endpackage

// File: rtl/rf_sb_cnt.sv
// Saturating pending-write counter for one register: +inc, -dec (0..2), clamped at zero.
module rf_sb_cnt
  import mips_rf_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic [1:0]       dec,
  output logic [CNT_W-1:0] cnt,
  output logic             underflow
);

  logic [CNT_W:0]   sum;
  logic [CNT_W:0]   dec_ext;
  logic [CNT_W-1:0] cnt_next;

  // inc is already gated by saturation upstream, so sum never exceeds the counter range.
  assign sum       = {1'b0, cnt} + {{CNT_W{1'b0}}, inc};
  assign dec_ext   = {{(CNT_W-1){1'b0}}, dec};
  assign underflow = (dec_ext > sum);

  always_comb begin
    cnt_next = cnt;
    if (underflow) begin
      cnt_next = '0;
    end else begin
      cnt_next = CNT_W'(sum - dec_ext);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with combinational bypassed read ports and a per-register pending-write scoreboard.
module regfile_scoreboard
  import mips_rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic                     issue_ready,
  input  logic                     wb_valid,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     kill_valid,
  input  logic [ADDR_W-1:0]        kill_addr,
  output logic                     sb_err
);

  localparam int NUM_REGS = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_FULL = {CNT_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;

  logic [DATA_W-1:0]                 regs [NUM_REGS];
  logic [NUM_REGS-1:0][CNT_W-1:0]    cnt_q;
  logic [NUM_REGS-1:0]               underflow;
  logic                              issue_fire;
  logic                              wb_live;
  logic                              kill_live;

  assign wb_live     = wb_valid && (wb_addr != ADDR_ZERO);
  assign kill_live   = kill_valid && (kill_addr != ADDR_ZERO);
  // Saturation looks only at the current count, never at a same-cycle write-back.
  assign issue_ready = (cnt_q[issue_addr] != CNT_FULL);
  assign issue_fire  = issue_valid && issue_ready && (issue_addr != ADDR_ZERO);

  assign cnt_q[0]     = '0;
  assign underflow[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
      logic       inc;
      logic [1:0] dec;
      assign inc = issue_fire && (issue_addr == ADDR_W'(gi));
      assign dec = {1'b0, wb_live && (wb_addr == ADDR_W'(gi))}
                 + {1'b0, kill_live && (kill_addr == ADDR_W'(gi))};
      rf_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (inc),
        .dec       (dec),
        .cnt       (cnt_q[gi]),
        .underflow (underflow[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
    end else if (wb_live) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_err <= 1'b0;
    end else if (|underflow) begin
      sb_err <= 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic              wb_hit;
      assign a      = rd_addr[gi*ADDR_W +: ADDR_W];
      assign wb_hit = wb_live && (wb_addr == a);
      assign rd_data[gi*DATA_W +: DATA_W] = (a == ADDR_ZERO) ? '0 :
                                            wb_hit ? wb_data : regs[a];
      // Final when nothing is pending, or the only pending write lands this cycle.
      assign rd_ready[gi] = (cnt_q[a] == '0) ||
                            ((cnt_q[a] == CNT_W'(1)) && wb_hit);
    end
  endgenerate

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default parameters, 2 read ports).
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_ready;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        kill_valid;
  logic [4:0]  kill_addr;
  logic        sb_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .issue_ready (issue_ready),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .kill_valid  (kill_valid),
    .kill_addr   (kill_addr),
    .sb_err      (sb_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    issue_addr  = '0;
    wb_valid    = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    kill_valid  = 1'b0;
    kill_addr   = '0;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1-2 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    rd_addr = '0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    // 1: reset state across all registers
    chk("reset_sb_err", 64'(sb_err), 64'h0);
    chk("reset_issue_ready", 64'(issue_ready), 64'h1);
    for (int r = 0; r < 32; r++) begin
      rd(5'(r), 5'(31 - r));
      chk($sformatf("reset_rd_data_r%0d", r), rd_data, 64'h0);
      chk($sformatf("reset_rd_ready_r%0d", r), 64'(rd_ready), 64'h3);
    end
    $display("step 1: reset sweep done");

    // 2: reserved write to r5 with same-cycle bypass
    issue_valid = 1'b1; issue_addr = 5'd5;
    tick();
    idle();
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    rd(5'd5, 5'd0);
    chk("bypass_r5_port0", rd_data, 64'h00000000_DEADBEEF);
    chk("bypass_r5_ready", 64'(rd_ready), 64'h3);
    tick();
    idle();
    rd(5'd0, 5'd5);
    chk("array_r5_port1", rd_data, 64'hDEADBEEF_00000000);
    chk("array_r5_sb_err", 64'(sb_err), 64'h0);
    $display("step 2: r5 write/bypass done");

    // 3: issue r7 then write it back
    issue_valid = 1'b1; issue_addr = 5'd7;
    tick();
    idle();
    rd(5'd7, 5'd7);
    chk("pending_r7_ready", 64'(rd_ready), 64'h0);
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234;
    #1;
    chk("wb_r7_ready", 64'(rd_ready), 64'h3);
    chk("wb_r7_data", rd_data, 64'h00001234_00001234);
    tick();
    idle();
    rd(5'd7, 5'd0);
    chk("after_r7_ready", 64'(rd_ready), 64'h3);
    chk("after_r7_sb_err", 64'(sb_err), 64'h0);
    $display("step 3: r7 reserve/write done");

    // 4: saturate r9, then kill and wb together
    issue_valid = 1'b1; issue_addr = 5'd9;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("sat_r9_ready_%0d", k), 64'(issue_ready), 64'h1);
      tick();
    end
    #1;
    chk("sat_r9_refused", 64'(issue_ready), 64'h0);
    tick();
    idle();
    issue_addr = 5'd9;
    rd(5'd9, 5'd0);
    chk("sat_r9_still_full", 64'(issue_ready), 64'h0);
    chk("sat_r9_rd_ready", 64'(rd_ready), 64'h2);
    kill_valid = 1'b1; kill_addr = 5'd9;
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'hCAFE0009;
    tick();
    idle();
    issue_addr = 5'd9;
    rd(5'd9, 5'd0);
    chk("kill_wb_r9_issue_ready", 64'(issue_ready), 64'h1);
    chk("kill_wb_r9_rd_ready", 64'(rd_ready), 64'h2);
    chk("kill_wb_r9_data", rd_data, 64'h00000000_CAFE0009);
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
    #1;
    chk("last_wb_r9_ready", 64'(rd_ready), 64'h3);
    tick();
    idle();
    rd(5'd9, 5'd9);
    chk("drained_r9_ready", 64'(rd_ready), 64'h3);
    chk("drained_r9_data", rd_data, 64'h00000099_00000099);
    chk("drained_r9_sb_err", 64'(sb_err), 64'h0);
    $display("step 4: r9 saturation/kill done");

    // 5: unreserved write sets sticky sb_err; r0 traffic is ignored
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
    tick();
    idle();
    rd(5'd3, 5'd0);
    chk("unres_r3_sb_err", 64'(sb_err), 64'h1);
    chk("unres_r3_data", rd_data, 64'h00000000_00000033);
    issue_valid = 1'b1; issue_addr = 5'd0;
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    kill_valid = 1'b1; kill_addr = 5'd0;
    rd(5'd0, 5'd0);
    chk("r0_issue_ready", 64'(issue_ready), 64'h1);
    chk("r0_no_bypass", rd_data, 64'h0);
    tick();
    idle();
    rd(5'd0, 5'd0);
    chk("r0_data", rd_data, 64'h0);
    chk("r0_ready", 64'(rd_ready), 64'h3);
    tick();
    chk("sticky_sb_err", 64'(sb_err), 64'h1);
    $display("step 5: sb_err and r0 rules done");

    // 6: reset mid-operation discards data and reservations
    wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
    tick();
    idle();
    issue_valid = 1'b1; issue_addr = 5'd4;
    tick();
    tick();
    idle();
    rd(5'd4, 5'd5);
    chk("pre_rst_r4_ready", 64'(rd_ready), 64'h2);
    chk("pre_rst_r4_data", rd_data[31:0], 64'h44);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    issue_addr = 5'd4;
    rd(5'd4, 5'd5);
    chk("post_rst_data", rd_data, 64'h0);
    chk("post_rst_ready", 64'(rd_ready), 64'h3);
    chk("post_rst_sb_err", 64'(sb_err), 64'h0);
    chk("post_rst_issue_ready", 64'(issue_ready), 64'h1);
    $display("step 6: mid-operation reset done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
